// File: rtl/s_packer_pkg.sv
// Shared constants for the query-sequence packer: default chunk geometry and
// the 2-bit base encoding used on the host stream.
package s_packer_pkg;

  localparam int PE_ARRAY_SIZE_DEF     = 64;
  localparam int PE_ARRAY_SIZE_LOG_DEF = 6;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

endpackage

// File: rtl/s_chunk_buffer.sv
// Two-slot ping-pong store: one slot fills from the base stream while the
// other waits to be issued as a chunk.
module s_chunk_buffer
  import s_packer_pkg::*;
#(
  parameter int PE_ARRAY_SIZE     = PE_ARRAY_SIZE_DEF,
  parameter int PE_ARRAY_SIZE_LOG = PE_ARRAY_SIZE_LOG_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [1:0]                     wr_base,
  input  logic                           wr_last,
  input  logic                           rd_en,
  output logic                           wr_ready,
  output logic                           head_full,
  output logic                           head_last,
  output logic [PE_ARRAY_SIZE*2-1:0]     head_data,
  output logic [PE_ARRAY_SIZE_LOG:0]     head_cnt
);

  localparam int CW = PE_ARRAY_SIZE_LOG + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PE_ARRAY_SIZE);

  logic [PE_ARRAY_SIZE*2-1:0] data_q [2];
  logic [CW-1:0]              cnt_q  [2];
  logic [1:0]                 last_q;
  logic [1:0]                 full_q;
  logic                       wptr_q;
  logic                       rptr_q;
  logic [CW-1:0]              cnt_nxt;
  logic                       close;

  assign cnt_nxt = cnt_q[wptr_q] + CW'(1);
  assign close   = (cnt_nxt == CNT_MAX) || wr_last;

  // A write only targets a non-full slot and a read only a full one, so the
  // two ports never touch the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      last_q <= '0;
      full_q <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      if (wr_en) begin
        for (int k = 0; k < PE_ARRAY_SIZE; k++) begin
          if (cnt_q[wptr_q] == CW'(k)) data_q[wptr_q][2*k +: 2] <= wr_base;
        end
        cnt_q[wptr_q] <= cnt_nxt;
        if (close) begin
          full_q[wptr_q] <= 1'b1;
          last_q[wptr_q] <= wr_last;
          wptr_q         <= ~wptr_q;
        end
      end
      if (rd_en) begin
        data_q[rptr_q] <= '0;
        cnt_q[rptr_q]  <= '0;
        full_q[rptr_q] <= 1'b0;
        last_q[rptr_q] <= 1'b0;
        rptr_q         <= ~rptr_q;
      end
    end
  end

  assign wr_ready  = rst_n && !full_q[wptr_q];
  assign head_full = full_q[rptr_q];
  assign head_last = last_q[rptr_q];
  assign head_data = data_q[rptr_q];
  assign head_cnt  = cnt_q[rptr_q];

endmodule

// File: rtl/s_packer.sv
// Packs the host base stream into PE-array-wide chunks and hands one chunk
// to the data processor per request, with a base count marking the tail.
module s_packer
  import s_packer_pkg::*;
#(
  parameter int PE_ARRAY_SIZE     = PE_ARRAY_SIZE_DEF,
  parameter int PE_ARRAY_SIZE_LOG = PE_ARRAY_SIZE_LOG_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_base_valid,
  input  logic [1:0]                 i_base,
  input  logic                       i_base_last,
  output logic                       o_base_ready,
  input  logic                       i_request_s,
  output logic [PE_ARRAY_SIZE*2-1:0] o_s,
  output logic [PE_ARRAY_SIZE_LOG:0] o_s_valid,
  output logic                       o_s_ack
);

  localparam int CW = PE_ARRAY_SIZE_LOG + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PE_ARRAY_SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, TERM} state_e;

  state_e                     state_q, state_d;
  logic                       issue;
  logic                       term_ack;
  logic                       head_full;
  logic                       head_last;
  logic [PE_ARRAY_SIZE*2-1:0] head_data;
  logic [CW-1:0]              head_cnt;
  logic [PE_ARRAY_SIZE*2-1:0] s_p1;
  logic [CW-1:0]              s_valid_p1;
  logic                       ack_p1;

  s_chunk_buffer #(
    .PE_ARRAY_SIZE     (PE_ARRAY_SIZE),
    .PE_ARRAY_SIZE_LOG (PE_ARRAY_SIZE_LOG)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (i_base_valid && o_base_ready),
    .wr_base   (i_base),
    .wr_last   (i_base_last),
    .rd_en     (issue),
    .wr_ready  (o_base_ready),
    .head_full (head_full),
    .head_last (head_last),
    .head_data (head_data),
    .head_cnt  (head_cnt)
  );

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    term_ack = 1'b0;
    unique case (state_q)
      IDLE: if (i_request_s) begin
        if (head_full) issue = 1'b1;
        else           state_d = WAIT;
      end
      WAIT: if (head_full) issue = 1'b1;
      TERM: if (i_request_s) begin
        term_ack = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A full-length final chunk owes the consumer an empty terminator chunk.
    if (issue) state_d = (head_cnt == CNT_MAX && head_last) ? TERM : IDLE;
  end

  // Stage p1: registered chunk output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_p1       <= '0;
      s_valid_p1 <= '0;
      ack_p1     <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_p1  <= issue || term_ack;
      if (issue) begin
        s_p1       <= head_data;
        s_valid_p1 <= head_cnt;
      end else if (term_ack) begin
        s_p1       <= '0;
        s_valid_p1 <= '0;
      end
    end
  end

  assign o_s       = s_p1;
  assign o_s_valid = s_valid_p1;
  assign o_s_ack   = ack_p1;

endmodule

// File: tb/tb_s_packer.sv
// Bench for s_packer with a 4-base chunk: table-driven cycles plus scripted
// corner cases, chunk contents checked against a scoreboard on each ack.
module tb_s_packer;
  import s_packer_pkg::*;

  localparam int N   = 4;
  localparam int LOG = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_base_valid;
  logic [1:0]     i_base;
  logic           i_base_last;
  logic           o_base_ready;
  logic           i_request_s;
  logic [2*N-1:0] o_s;
  logic [LOG:0]   o_s_valid;
  logic           o_s_ack;

  always #5 clk = ~clk;

  s_packer #(.PE_ARRAY_SIZE(N), .PE_ARRAY_SIZE_LOG(LOG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_base_valid (i_base_valid),
    .i_base       (i_base),
    .i_base_last  (i_base_last),
    .o_base_ready (o_base_ready),
    .i_request_s  (i_request_s),
    .o_s          (o_s),
    .o_s_valid    (o_s_valid),
    .o_s_ack      (o_s_ack)
  );

  typedef struct packed {
    logic [2*N-1:0] data;
    logic [LOG:0]   cnt;
  } chunk_t;

  typedef struct {
    logic           v;
    logic [1:0]     b;
    logic           l;
    logic           r;
    logic           push;
    logic [2*N-1:0] pdata;
    logic [LOG:0]   pcnt;
    logic           ack;
    logic           chk_rdy;
    logic           rdy;
  } vec_t;

  chunk_t     sb[$];
  vec_t       tbl[13];
  logic [1:0] bp[10];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic chunk_t mk_chunk(input int start, input int cnt);
    chunk_t c;
    c.data = '0;
    for (int i = 0; i < cnt; i++) c.data[2*i +: 2] = bp[start+i];
    c.cnt = (LOG+1)'(cnt);
    return c;
  endfunction

  // Called just after a rising edge; drives one cycle and samples mid-cycle.
  task automatic cycle(input logic v, input logic [1:0] b, input logic l, input logic r,
                       input logic exp_ack, input logic chk_rdy, input logic exp_rdy,
                       input string tag);
    chunk_t c;
    i_base_valid = v;
    i_base       = b;
    i_base_last  = l;
    i_request_s  = r;
    @(negedge clk);
    if (chk_rdy) check({tag, " ready"}, 32'(o_base_ready), 32'(exp_rdy));
    check({tag, " ack"}, 32'(o_s_ack), 32'(exp_ack));
    if (o_s_ack) begin
      if (sb.size() == 0) begin
        check({tag, " spurious ack"}, 32'(o_s_ack), 32'd0);
      end else begin
        c = sb.pop_front();
        check({tag, " o_s"}, 32'(o_s), 32'(c.data));
        check({tag, " o_s_valid"}, 32'(o_s_valid), 32'(c.cnt));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    rst_n        = 1'b0;
    i_base_valid = 1'b0;
    i_base       = 2'd0;
    i_base_last  = 1'b0;
    i_request_s  = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, " o_s"}, 32'(o_s), 32'd0);
    check({tag, " o_s_valid"}, 32'(o_s_valid), 32'd0);
    check({tag, " ack"}, 32'(o_s_ack), 32'd0);
    check({tag, " ready"}, 32'(o_base_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    //          v     base    last  req   push  pdata  pcnt  ack   chk   rdy
    tbl[0]  = '{1'b1, BASE_A, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, BASE_C, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, BASE_G, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, BASE_A, 1'b0, 1'b1, 1'b1, 8'h24, 3'd3, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, BASE_A, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, BASE_T, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, BASE_T, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, BASE_T, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, BASE_T, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, BASE_A, 1'b0, 1'b1, 1'b1, 8'hFF, 3'd4, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, BASE_A, 1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, BASE_A, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, BASE_A, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};

    bp = '{BASE_T, BASE_C, BASE_A, BASE_G, BASE_G, BASE_T, BASE_C, BASE_A, BASE_C, BASE_G};

    apply_reset("init reset");

    // Short sequence, then a full-length final chunk followed by its terminator.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].push) sb.push_back('{data: tbl[i].pdata, cnt: tbl[i].pcnt});
      cycle(tbl[i].v, tbl[i].b, tbl[i].l, tbl[i].r, tbl[i].ack, tbl[i].chk_rdy, tbl[i].rdy,
            $sformatf("tbl[%0d]", i));
    end

    // Early request: pending through WAIT, extra request ignored.
    sb.push_back('{data: 8'h42, cnt: 3'd4});
    cycle(1'b0, BASE_A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "early req");
    cycle(1'b1, BASE_G, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "early b0");
    cycle(1'b1, BASE_A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "early b1+req");
    cycle(1'b1, BASE_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "early b2");
    cycle(1'b1, BASE_C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "early b3");
    cycle(1'b0, BASE_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "early +1");
    cycle(1'b0, BASE_A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "early +2");
    cycle(1'b0, BASE_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "early +3");
    cycle(1'b0, BASE_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "early +4");

    // Back-pressure: both slots fill, ready drops until the ack frees one.
    for (int k = 0; k < 8; k++)
      cycle(1'b1, bp[k], 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, $sformatf("bp fill%0d", k));
    cycle(1'b1, bp[8], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "bp full");
    sb.push_back(mk_chunk(0, 4));
    cycle(1'b1, bp[8], 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "bp req");
    cycle(1'b1, bp[8], 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "bp ack");
    cycle(1'b1, bp[9], 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "bp last");
    sb.push_back(mk_chunk(4, 4));
    cycle(1'b0, BASE_A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "bp req2");
    sb.push_back(mk_chunk(8, 2));
    cycle(1'b0, BASE_A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "bp req3");
    cycle(1'b0, BASE_A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "bp ack3");
    cycle(1'b0, BASE_A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "bp drained");

    // Reset with a partial chunk and an outstanding request.
    cycle(1'b1, BASE_G, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst b0");
    cycle(1'b1, BASE_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst b1");
    cycle(1'b0, BASE_A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rst req");
    apply_reset("mid reset");
    cycle(1'b1, BASE_C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "post b0");
    sb.push_back('{data: 8'h01, cnt: 3'd1});
    cycle(1'b0, BASE_A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "post req");
    cycle(1'b0, BASE_A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "post ack");
    cycle(1'b0, BASE_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post idle");

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_packer.md
# s_packer

- Upstream stage of the data processor.
- Accepts the query sequence S from the host as a stream of 2-bit bases and packs them into PE-array-wide chunks in a two-slot ping-pong buffer.
- Returns one chunk per `o_request_s` pulse from the data processor, with a base count.
- A count below `PE_ARRAY_SIZE` marks the final chunk; a count of 0 marks a sequence that has ended on a chunk boundary.

## Interface
- `PE_ARRAY_SIZE`, default 64: bases per chunk (mirrors `` `PE_Array_size ``).
- `PE_ARRAY_SIZE_LOG`, default 6: log2 of `PE_ARRAY_SIZE` (mirrors `` `PE_Array_size_log ``).
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `i_base_valid`, in, 1: host base valid.
- `i_base`, in, 2: base code (A=0, C=1, G=2, T=3).
- `i_base_last`, in, 1: qualifies the final base of S.
- `o_base_ready`, out, 1: packer can accept a base. A transfer occurs when `i_base_valid` && `o_base_ready`.
- `i_request_s`, in, 1: one-cycle chunk request from the data processor.
- `o_s`, out, `PE_ARRAY_SIZE*2`: chunk data. Base k sits at `[2k+1:2k]`, and the first base is at `[1:0]`.
- `o_s_valid`, out, `PE_ARRAY_SIZE_LOG+1`: number of valid bases in `o_s`.
- `o_s_ack`, out, 1: one-cycle pulse. `o_s`/`o_s_valid` are updated in this cycle and held until the next ack.

## Operation
- **Buffer:** two slots, each holding data, a count, a last flag and a full flag. A write pointer selects the fill slot; a read pointer selects the head slot.
- **Filling:** each transfer writes the base at index count and increments count.
- **Closing a slot:** a slot closes (full=1, write pointer toggles) when count reaches `PE_ARRAY_SIZE` or on a transfer with `i_base_last`. The slot's last flag is set to `i_base_last`.
- **Next sequence:** bases of the next sequence may enter the other slot immediately after a slot closes.
- **Ready:** `o_base_ready` = rst_n && !full[write pointer]. It is combinational from registered flags.
- **Unused bits:** bits above the count in a closed slot are 0.
- **Output FSM states:**
  - `IDLE`: no request outstanding.
  - `WAIT`: a request is outstanding and the head slot is not full.
  - `TERM`: the last chunk sent had count `PE_ARRAY_SIZE` with its last flag set.
- **IDLE + `i_request_s`:**
  - If head is full: issue the chunk on the next cycle.
  - Otherwise go to `WAIT`.
- **WAIT:** when the head becomes full, issue the chunk. Any further `i_request_s` pulses while in `WAIT` are ignored (not queued).
- **Issue:**
  - Register the head slot's data and count onto `o_s`/`o_s_valid`, pulse `o_s_ack`, and clear the head's full flag.
  - Clear the slot's data and count so it can refill, and toggle the read pointer.
  - If the chunk's count is `PE_ARRAY_SIZE` and its last flag is set, go to `TERM`; otherwise go to `IDLE`.
- **TERM + `i_request_s`:** the next cycle outputs `o_s`=0, `o_s_valid`=0, `o_s_ack`=1, then go to `IDLE`. No slot is consumed.
- **Arithmetic:** counts are `PE_ARRAY_SIZE_LOG+1` bits, unsigned, and never exceed `PE_ARRAY_SIZE`.

## Timing
- **Reset (synchronous):** while `rst_n`=0, all of the following are 0: `o_s`, `o_s_valid`, `o_s_ack`, `o_base_ready`, both slots, both pointers. The FSM is held in `IDLE`.
  - A partial chunk or outstanding request present at reset is discarded.
  - `o_base_ready` goes to 1 in the first cycle with `rst_n`=1.
- **Request latency:** `i_request_s` in cycle n with the head full at n gives `o_s_ack` in cycle n+1.
- **Pending-request latency:** in `WAIT`, if the slot closes at the edge ending cycle m, the head is full in cycle m+1 and `o_s_ack` is asserted in cycle m+2.
- **Simultaneous fill and issue:** a slot closing and the other slot being issued in the same cycle is legal. Both take effect at the same edge.
- **Both slots full:** `o_base_ready`=0. It returns to 1 in the cycle `o_s_ack` is high, because the slot is freed at that edge.
- **Request in the ack cycle:** `i_request_s` asserted in the same cycle as `o_s_ack` is a new request and is serviced normally.
- **Throughput:** one base per cycle sustained when requests keep pace.

## Structure
- The shared define file (`src/util.v`) supplies `` `PE_Array_size `` and `` `PE_Array_size_log ``. The parameter defaults tie to those macros.
- The base encoding constants also belong in `src/util.v`.
- FSM state encoding is local to the block.
- One sub-module: `s_chunk_buffer`, the two-slot ping-pong store with the fill/issue port. The FSM and handshake live in `s_packer`.

## Test plan
All scenarios use `PE_ARRAY_SIZE`=4.
- **Short sequence:** stream A,C,G (last on G), then request → ack one cycle later with `o_s`=8'h24, `o_s_valid`=3.
- **Boundary-length sequence:** stream 4 bases T,T,T,T (last), request → `o_s`=8'hFF, `o_s_valid`=4. A second request → `o_s`=0, `o_s_valid`=0, ack.
- **Early request:** request before any base, then feed 4 bases G,A,A,C (the 4th without last) → ack exactly 2 cycles after the 4th transfer with `o_s`=8'h42, `o_s_valid`=4. An extra request during `WAIT` produces no second ack.
- **Back-pressure:** feed 10 bases continuously with no request → `o_base_ready` drops after the 8th transfer. A request → ack, and `o_base_ready`=1 in the ack cycle.
- **Reset mid-operation:** reset after 2 bases with a request outstanding → all outputs 0, no ack. After reset, a new 1-base sequence (C, last) → `o_s_valid`=1, `o_s`=8'h01.
